imem_loader: RTL

Program loader that fills the single-cycle CPU's instruction memory before execution. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word to the instruction memory's write port at consecutive word addresses, matching the memory's word-indexed PC. While loading, it holds the CPU off; completion is flagged with `done` and a running XOR checksum.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: gathers a big-endian byte stream into 32-bit words
// and writes them to consecutive word addresses while holding the CPU off.
module imem_loader #(
    parameter int DEPTH  = 17,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic [1:0]        dbg_state
);

    // Byte handshake: a byte moves when in_valid && in_ready at a rising edge;
    // in_ready depends only on state, never on in_valid.
    // dbg_state encoding: 0 IDLE, 1 LOAD, 2 WRITE, 3 DONE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              error_q, error_d;

    logic              count_ok;
    logic [ADDR_W:0]   idx_inc;
    logic [31:0]       word_shift;

    assign count_ok   = (word_count != '0) && (word_count <= DEPTH_W);
    assign idx_inc    = {1'b0, idx_q} + ONE_W;
    assign word_shift = {word_q[23:0], in_data};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        word_d     = word_q;
        addr_d     = addr_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        error_d    = error_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (count_ok) begin
                        state_d    = S_LOAD;
                        idx_d      = '0;
                        byte_cnt_d = '0;
                        checksum_d = '0;
                        error_d    = 1'b0;
                        count_d    = word_count;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    word_d     = word_shift;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Output registers are loaded here so they are valid
                        // throughout WRITE and hold afterwards.
                        state_d = S_WRITE;
                        addr_d  = idx_q;
                        data_d  = word_shift;
                    end
                end
            end
            S_WRITE: begin
                checksum_d = checksum_q ^ data_q;
                if (idx_inc == count_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_LOAD;
                    idx_d      = idx_inc[ADDR_W-1:0];
                    byte_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            error_q    <= error_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign wr_en     = (state_q == S_WRITE);
    assign busy      = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign cpu_hold  = busy;
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign wr_addr   = {{(32-ADDR_W){1'b0}}, addr_q};
    assign wr_data   = data_q;
    assign checksum  = checksum_q;
    assign dbg_state = state_q;

endmodule
